// File: rtl/kyber_out_streamer.sv
// kyber_out_streamer
//   Word-serial transmitter for the kyber core results. On a rising edge of
//   finish_i the mode-selected payload is captured into a local buffer and
//   streamed LSB-first as DATA_W-bit words over a valid/ready interface.
//
//   Optional feature macro: KYBER_STREAM_HDR_EN -- prefixes every transfer
//   with one header word {.., N[11:0] at [19:8], 6'b0, mode[1:0]}.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   finish_i, mode_i    core completion level and mode (0 KeyGen,1 Enc,2 Dec)
//   pk_out_i..m_out_i   core result buses
//   tdata_o/tvalid_o/tready_i/tlast_o   output stream
//   busy_o              transfer in progress (SEND or END)
//   done_o              one-cycle pulse after the last word is accepted
//   err_o               sticky: capture while busy, or reserved mode
module kyber_out_streamer #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              finish_i,
  input  logic [1:0]        mode_i,
  input  logic [6399:0]     pk_out_i,
  input  logic [6143:0]     sk_out_i,
  input  logic [6143:0]     c_out_i,
  input  logic [255:0]      m_out_i,
  output logic [DATA_W-1:0] tdata_o,
  output logic              tvalid_o,
  input  logic              tready_i,
  output logic              tlast_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
    $error("kyber_out_streamer: DATA_W must be 32 or 64");
  end

  localparam int PAY_W = 12544;
`ifdef KYBER_STREAM_HDR_EN
  localparam int BUF_W = PAY_W + DATA_W;
`else
  localparam int BUF_W = PAY_W;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_END} state_e;

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [8:0]         cnt_q, cnt_d;
  logic [8:0]         last_q, last_d;
  logic               err_q, err_d;
  logic               finish_d_q;

  logic               cap;
  logic [PAY_W-1:0]   pay;
  logic [8:0]         n_words;
  logic [BUF_W-1:0]   load;
  logic [8:0]         last_idx;

  assign cap = finish_i & ~finish_d_q;

  // Payload selection and word count for the current mode.
  always_comb begin
    pay     = '0;
    n_words = '0;
    case (mode_i)
      2'd0: begin pay = {sk_out_i, pk_out_i};  n_words = 9'(12544 / DATA_W); end
      2'd1: begin pay = PAY_W'(c_out_i);       n_words = 9'(6144 / DATA_W);  end
      2'd2: begin pay = PAY_W'(m_out_i);       n_words = 9'(256 / DATA_W);   end
      default: ;
    endcase
  end

`ifdef KYBER_STREAM_HDR_EN
  // Header occupies word 0 so the payload shifts up by one word.
  assign load     = {pay, {(DATA_W-20){1'b0}}, 3'b000, n_words, 6'b000000, mode_i};
  assign last_idx = n_words;
`else
  assign load     = pay;
  assign last_idx = n_words - 9'd1;
`endif

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (cap) begin
          if (mode_i == 2'd3) begin
            err_d = 1'b1;
          end else begin
            buf_d   = load;
            cnt_d   = '0;
            last_d  = last_idx;
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (cap) err_d = 1'b1;
        if (tready_i) begin
          buf_d = buf_q >> DATA_W;
          cnt_d = cnt_q + 9'd1;
          if (cnt_q == last_q) state_d = S_END;
        end
      end
      S_END: begin
        if (cap) err_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      buf_q      <= '0;
      cnt_q      <= '0;
      last_q     <= '0;
      err_q      <= 1'b0;
      // Held-high finish through reset must not look like a rising edge.
      finish_d_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      err_q      <= err_d;
      finish_d_q <= finish_i;
    end
  end

  // All handshake outputs come from registers only; tready_i never reaches tvalid_o.
  assign tdata_o  = buf_q[DATA_W-1:0];
  assign tvalid_o = (state_q == S_SEND);
  assign tlast_o  = (state_q == S_SEND) && (cnt_q == last_q);
  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = (state_q == S_END);
  assign err_o    = err_q;

endmodule

// File: tb/tb_kyber_out_streamer.sv
module tb_kyber_out_streamer;
`ifdef KYBER_STREAM_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic clk = 0;
  logic rst, finish, tready;
  logic [1:0] mode;
  logic [6399:0] pk, e_pk;
  logic [6143:0] sk, c, e_sk, e_c;
  logic [255:0] m, e_m;
  logic [31:0] tdata;
  logic tvalid, tlast, busy, done, err;

  int total = 0, bad = 0;
  logic [31:0] got [0:399];
  int ngot;

  always #5 clk = ~clk;

  kyber_out_streamer #(.DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .finish_i(finish), .mode_i(mode),
    .pk_out_i(pk), .sk_out_i(sk), .c_out_i(c), .m_out_i(m),
    .tdata_o(tdata), .tvalid_o(tvalid), .tready_i(tready), .tlast_o(tlast),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int n_of(input int md);
    case (md)
      0: return 392;
      1: return 192;
      default: return 8;
    endcase
  endfunction

  function automatic logic [31:0] exp_w(input int md, input int k);
    logic [12543:0] b;
    int j;
    if (HDR == 1 && k == 0) return {12'h0, 12'(n_of(md)), 6'h0, 2'(md)};
    j = k - HDR;
    case (md)
      0: b = {e_sk, e_pk};
      1: b = 12544'(e_c);
      default: b = 12544'(e_m);
    endcase
    return b[j*32 +: 32];
  endfunction

  // Raise finish for one cycle at the current negedge, snapshot the buses,
  // then scramble them so the DUT must stream from its captured copy.
  task automatic start(input logic [1:0] md);
    mode = md; finish = 1;
    e_pk = pk; e_sk = sk; e_c = c; e_m = m;
    @(posedge clk); #1;
    finish = 0;
    pk = ~pk; sk = ~sk; c = ~c; m = ~m;
  endtask

  // Receive one transfer, checking stall stability, tlast, done/busy timing
  // and every data word. Returns at the negedge of the first idle cycle.
  task automatic collect(input int md, input bit rnd, input int budget);
    logic [31:0] pd;
    logic pl;
    bit stalled;
    int cyc, first, tot;
    tot = n_of(md) + HDR;
    ngot = 0; stalled = 0; cyc = 0; first = -1; pd = '0; pl = 0;
    while (ngot < tot && cyc < budget) begin
      @(negedge clk); cyc++;
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        check("stall_vld", tvalid, 1);
        check("stall_data", tdata, pd);
        check("stall_last", tlast, pl);
      end
      if (tvalid) begin
        if (tready) begin
          if (first < 0) first = cyc;
          got[ngot] = tdata;
          check("tlast", tlast, ngot == tot - 1);
          ngot++; stalled = 0;
        end else begin
          stalled = 1; pd = tdata; pl = tlast;
        end
      end
    end
    check("word_count", ngot, tot);
    if (!rnd) begin
      check("first_lat", first, 1);
      check("last_at_N", cyc, tot);
    end
    @(negedge clk);
    tready = 0;
    check("done_hi", done, 1);
    check("busy_end", busy, 1);
    check("vld_end", tvalid, 0);
    @(negedge clk);
    check("done_lo", done, 0);
    check("busy_lo", busy, 0);
    for (int k = 0; k < ngot; k++) check("data", got[k], exp_w(md, k));
  endtask

  initial begin
    int cnt, guard;
    bit saw;
    rst = 1; finish = 1; tready = 0; mode = 2;
    pk = '0; sk = '0; c = '0; m = '0;
    repeat (3) @(negedge clk);
    check("rst_vld", tvalid, 0); check("rst_last", tlast, 0);
    check("rst_busy", busy, 0); check("rst_done", done, 0);
    check("rst_err", err, 0); check("rst_data", tdata, 0);
    // finish held high across reset release must not capture
    rst = 0;
    repeat (5) @(negedge clk);
    check("no_cap_held", busy, 0);
    finish = 0;
    @(negedge clk);

    // Dec, then a back-to-back Dec in the first idle cycle
    m = 256'h0f;
    start(2); collect(2, 0, 50);
`ifdef KYBER_STREAM_HDR_EN
    check("hdr_word", got[0], 32'h00000802);
    check("dec_w0", got[1], 32'h0000000f);
`else
    check("dec_w0", got[0], 32'h0000000f);
    check("dec_w7", got[7], 32'h0);
`endif
    m = {32'hdeadbeef, 192'h0, 32'h12345678};
    start(2); collect(2, 0, 50);

    // KeyGen with counting patterns
    for (int i = 0; i < 200; i++) pk[i*32 +: 32] = i;
    for (int i = 0; i < 192; i++) sk[i*32 +: 32] = 32'ha0000000 + i;
    start(0); collect(0, 0, 1000);
    check("kg_w199", got[199 + HDR], 32'd199);
    check("kg_w200", got[200 + HDR], 32'ha0000000);

    // Enc with random backpressure
    for (int i = 0; i < 192; i++) c[i*32 +: 32] = $urandom;
    start(1); collect(1, 1, 3000);
    check("err_clean", err, 0);

    // finish rises again mid-transfer
    for (int i = 0; i < 192; i++) c[i*32 +: 32] = $urandom;
    start(1);
    fork
      collect(1, 0, 1000);
      begin
        repeat (30) @(negedge clk);
        finish = 1;
        @(negedge clk);
        finish = 0;
      end
    join
    check("err_mid", err, 1);

    // reset at word 50 of Enc with finish held high
    for (int i = 0; i < 192; i++) c[i*32 +: 32] = $urandom;
    mode = 1; finish = 1; tready = 1;
    cnt = 0; guard = 0;
    while (cnt < 50 && guard < 200) begin
      @(negedge clk); guard++;
      if (tvalid && tready) cnt++;
    end
    check("rst_reach50", cnt, 50);
    rst = 1;
    @(negedge clk);
    rst = 0; tready = 0;
    check("mrst_vld", tvalid, 0); check("mrst_done", done, 0);
    check("mrst_busy", busy, 0); check("mrst_last", tlast, 0);
    check("mrst_err", err, 0);
    saw = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || tvalid || done) saw = 1;
    end
    check("mrst_no_restart", saw, 0);
    finish = 0;
    @(negedge clk);
    start(1); collect(1, 0, 1000);

    // reserved mode: error, no words
    mode = 3; finish = 1;
    @(posedge clk); #1;
    finish = 0;
    saw = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || tvalid) saw = 1;
    end
    check("m3_no_words", saw, 0);
    check("m3_err", err, 1);
    repeat (5) @(negedge clk);
    check("err_sticky", err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
